// File: rtl/md_sequencer_if.sv
// Request/result bundle between the pipeline controller and the multiply/divide sequencer.
interface md_sequencer_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  Op;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output A, B, Op, Start, input Busy, HI, LO);
  modport slave  (input A, B, Op, Start, output Busy, HI, LO);
endinterface

// File: rtl/md_sequencer.sv
// Iterative 32x32 multiply / 32/32 divide unit owning HI/LO.
// 32 RUN steps plus one FIX cycle of sign correction and commit.
module md_sequencer (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // acc holds product-high / remainder; mq holds multiplier / quotient.
  logic [31:0] acc_q, acc_d;
  logic [31:0] mq_q, mq_d;
  logic [31:0] opnd_q, opnd_d;
  logic        isdiv_q, isdiv_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;

  logic        sgn_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [63:0] prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    isdiv_d = isdiv_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    sgn_op  = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
    a_neg   = sgn_op & bus.A[31];
    b_neg   = sgn_op & bus.B[31];
    a_mag   = a_neg ? (~bus.A + 32'd1) : bus.A;
    b_mag   = b_neg ? (~bus.B + 32'd1) : bus.B;
    sum     = {1'b0, acc_q} + {1'b0, opnd_q};
    shifted = {acc_q, mq_q[31]};
    diff    = shifted - {1'b0, opnd_q};
    prod    = {acc_q, mq_q};

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          case (op_e'(bus.Op))
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              isdiv_d = bus.Op[1];
              acc_d   = '0;
              mq_d    = bus.Op[1] ? a_mag : b_mag;
              opnd_d  = bus.Op[1] ? b_mag : a_mag;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dz_d    = bus.Op[1] && (bus.B == '0);
              cnt_d   = '0;
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (isdiv_q) begin
          // Restoring step: keep the trial difference only when it did not go negative.
          if (!diff[32]) begin
            acc_d = diff[31:0];
            mq_d  = {mq_q[30:0], 1'b1};
          end else begin
            acc_d = shifted[31:0];
            mq_d  = {mq_q[30:0], 1'b0};
          end
        end else if (mq_q[0]) begin
          acc_d = sum[32:1];
          mq_d  = {sum[0], mq_q[31:1]};
        end else begin
          acc_d = {1'b0, acc_q[31:1]};
          mq_d  = {acc_q[0], mq_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!isdiv_q) begin
          {hi_d, lo_d} = neg_q ? (~prod + 64'd1) : prod;
        end else if (!dz_q) begin
          lo_d = neg_q  ? (~mq_q + 32'd1)  : mq_q;
          hi_d = rneg_q ? (~acc_q + 32'd1) : acc_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      isdiv_q <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      isdiv_q <= isdiv_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
